// File: rtl/m_dm.sv
// m_dm: M-stage data memory for the five-stage pipeline.
// Word-array storage with byte/halfword/word stores merged by read-modify-write,
// sign- or zero-extended combinational loads, and a log line per committed store.
module m_dm #(
    parameter int          DEPTH = 3072,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] M_PC,
    input  logic        M_memWrite,
    input  logic [2:0]  M_memOp,
    input  logic [31:0] M_addr,
    input  logic [31:0] M_writeData,
    output logic [31:0] M_dataOut
);

    localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

    // Access width after folding the five memOp codes; signedness is kept apart.
    typedef enum logic [1:0] {
        SIZE_WORD,
        SIZE_HALF,
        SIZE_BYTE
    } accessSize_t;

    logic [31:0]      mem [DEPTH];

    logic [31:0]      off;
    logic             inRange;
    logic [IDX_W-1:0] idx;
    logic [31:0]      curWord;
    logic [31:0]      wordAddr;
    accessSize_t      accessSize;
    logic             signedLoad;
    logic [31:0]      mergedWord;
    logic [15:0]      loadHalf;
    logic [7:0]       loadByte;

    // Offset wraps, so addresses below BASE land far above the array and read as out of range.
    assign off      = M_addr - BASE;
    assign inRange  = off < SPAN;
    assign idx      = off[IDX_W+1:2];
    assign curWord  = inRange ? mem[idx] : 32'h0;
    assign wordAddr = BASE + {{(30-IDX_W){1'b0}}, idx, 2'b00};

    // Decode memOp into width and signedness; unknown codes behave as word.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        accessSize = SIZE_WORD;
        signedLoad = 1'b0;
        case (M_memOp)
            3'b001: begin
                accessSize = SIZE_HALF;
                signedLoad = 1'b1;
            end
            3'b010: accessSize = SIZE_HALF;
            3'b011: begin
                accessSize = SIZE_BYTE;
                signedLoad = 1'b1;
            end
            3'b100: accessSize = SIZE_BYTE;
            default: ;
        endcase
    end

    // Build the post-store word: only the addressed lane(s) take new data.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' so later lines see earlier results in the same pass.
        mergedWord = curWord;
        case (accessSize)
            SIZE_HALF: begin
                if (off[1]) mergedWord[31:16] = M_writeData[15:0];
                else        mergedWord[15:0]  = M_writeData[15:0];
            end
            SIZE_BYTE: begin
                case (off[1:0])
                    2'd0:    mergedWord[7:0]   = M_writeData[7:0];
                    2'd1:    mergedWord[15:8]  = M_writeData[7:0];
                    2'd2:    mergedWord[23:16] = M_writeData[7:0];
                    default: mergedWord[31:24] = M_writeData[7:0];
                endcase
            end
            default: mergedWord = M_writeData;
        endcase
    end

    // Pick the loaded lane out of the current word.
    always_comb begin
        loadHalf = off[1] ? curWord[31:16] : curWord[15:0];
        case (off[1:0])
            2'd0:    loadByte = curWord[7:0];
            2'd1:    loadByte = curWord[15:8];
            2'd2:    loadByte = curWord[23:16];
            default: loadByte = curWord[31:24];
        endcase
    end

    // Extend the selected lane; out-of-range reads give 0 because curWord is 0 there.
    always_comb begin
        M_dataOut = 32'h0;
        case (accessSize)
            SIZE_HALF: M_dataOut = {{16{signedLoad & loadHalf[15]}}, loadHalf};
            SIZE_BYTE: M_dataOut = {{24{signedLoad & loadByte[7]}}, loadByte};
            default:   M_dataOut = curWord;
        endcase
    end

    // Commit in-range stores on the edge; reset clears the whole array without waiting for clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the array is explicitly reset because loads right after reset must read 0, not stale data.
            for (int i = 0; i < DEPTH; i++) begin
                mem[IDX_W'(i)] <= 32'h0;
            end
        end else if (M_memWrite && inRange) begin
            // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
            mem[idx] <= mergedWord;
`ifndef SYNTHESIS
            $write("%d@%h: *%h <= %h\n", $time, M_PC, wordAddr, mergedWord);
`endif
        end
    end

endmodule

// File: tb/tb_m_dm.sv
// tb_m_dm: directed bench for m_dm with hand-computed expected values.
// Inputs change on the falling edge; loads are sampled 1 ns later, away from the rising edge.
module tb_m_dm;

    logic        clk;
    logic        reset;
    logic [31:0] M_PC;
    logic        M_memWrite;
    logic [2:0]  M_memOp;
    logic [31:0] M_addr;
    logic [31:0] M_writeData;
    logic [31:0] M_dataOut;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] OP_W  = 3'b000;
    localparam logic [2:0] OP_HS = 3'b001;
    localparam logic [2:0] OP_HU = 3'b010;
    localparam logic [2:0] OP_BS = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;

    m_dm #(.DEPTH(3072), .BASE(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .M_PC       (M_PC),
        .M_memWrite (M_memWrite),
        .M_memOp    (M_memOp),
        .M_addr     (M_addr),
        .M_writeData(M_writeData),
        .M_dataOut  (M_dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a store for the coming rising edge.
    task automatic putStore(input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] pc);
        M_memWrite  = 1'b1;
        M_memOp     = op;
        M_addr      = addr;
        M_writeData = data;
        M_PC        = pc;
    endtask

    // Present a load (no store) and let the combinational path settle.
    task automatic putLoad(input logic [2:0] op, input logic [31:0] addr);
        M_memWrite  = 1'b0;
        M_memOp     = op;
        M_addr      = addr;
        M_writeData = 32'h0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        putLoad(OP_W, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        putLoad(OP_W, 32'h0000_0000);
        total++;
        if (M_dataOut !== 32'h0) begin
            bad++;
            $display("FAIL reset_lw_0: got %h want %h", M_dataOut, 32'h0);
        end
        putLoad(OP_W, 32'h0000_2FFC);
        total++;
        if (M_dataOut !== 32'h0) begin
            bad++;
            $display("FAIL reset_lw_2ffc: got %h want %h", M_dataOut, 32'h0);
        end
        putLoad(OP_W, 32'h0000_3000);
        total++;
        if (M_dataOut !== 32'h0) begin
            bad++;
            $display("FAIL reset_lw_3000: got %h want %h", M_dataOut, 32'h0);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word_store;
        putStore(OP_W, 32'h10, 32'h1234_5678, 32'h0000_3000);
        #1;
        total++;
        if (M_dataOut !== 32'h0) begin
            bad++;
            $display("FAIL word_same_cycle: got %h want %h", M_dataOut, 32'h0);
        end
        @(negedge clk);
        putLoad(OP_W, 32'h10);
        total++;
        if (M_dataOut !== 32'h1234_5678) begin
            bad++;
            $display("FAIL word_next_cycle: got %h want %h", M_dataOut, 32'h1234_5678);
        end
        @(negedge clk);
    endtask

    task automatic test_merge;
        putStore(OP_BS, 32'h23, 32'h0000_00AB, 32'h0000_3004);
        @(negedge clk);
        putStore(OP_HS, 32'h20, 32'h0000_80FF, 32'h0000_3008);
        #1;
        total++;
        if (M_dataOut !== 32'h0) begin
            bad++;
            $display("FAIL merge_same_cycle_lh: got %h want %h", M_dataOut, 32'h0);
        end
        @(negedge clk);
        putLoad(OP_W, 32'h20);
        total++;
        if (M_dataOut !== 32'hAB00_80FF) begin
            bad++;
            $display("FAIL merge_lw: got %h want %h", M_dataOut, 32'hAB00_80FF);
        end
        putLoad(OP_BS, 32'h23);
        total++;
        if (M_dataOut !== 32'hFFFF_FFAB) begin
            bad++;
            $display("FAIL merge_lb: got %h want %h", M_dataOut, 32'hFFFF_FFAB);
        end
        putLoad(OP_BU, 32'h23);
        total++;
        if (M_dataOut !== 32'h0000_00AB) begin
            bad++;
            $display("FAIL merge_lbu: got %h want %h", M_dataOut, 32'h0000_00AB);
        end
        putLoad(OP_HS, 32'h20);
        total++;
        if (M_dataOut !== 32'hFFFF_80FF) begin
            bad++;
            $display("FAIL merge_lh: got %h want %h", M_dataOut, 32'hFFFF_80FF);
        end
        putLoad(OP_HU, 32'h22);
        total++;
        if (M_dataOut !== 32'h0000_AB00) begin
            bad++;
            $display("FAIL merge_lhu: got %h want %h", M_dataOut, 32'h0000_AB00);
        end
        putLoad(OP_BU, 32'h21);
        total++;
        if (M_dataOut !== 32'h0000_0080) begin
            bad++;
            $display("FAIL merge_lbu_lane1: got %h want %h", M_dataOut, 32'h0000_0080);
        end
        @(negedge clk);
    endtask

    task automatic test_align;
        putStore(OP_W, 32'h43, 32'hDEAD_BEEF, 32'h0000_300C);
        @(negedge clk);
        putLoad(OP_W, 32'h40);
        total++;
        if (M_dataOut !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL align_lw: got %h want %h", M_dataOut, 32'hDEAD_BEEF);
        end
        putLoad(OP_HS, 32'h41);
        total++;
        if (M_dataOut !== 32'hFFFF_BEEF) begin
            bad++;
            $display("FAIL align_lh_41: got %h want %h", M_dataOut, 32'hFFFF_BEEF);
        end
        putLoad(OP_HU, 32'h43);
        total++;
        if (M_dataOut !== 32'h0000_DEAD) begin
            bad++;
            $display("FAIL align_lhu_43: got %h want %h", M_dataOut, 32'h0000_DEAD);
        end
        putLoad(OP_BS, 32'h42);
        total++;
        if (M_dataOut !== 32'hFFFF_FFAD) begin
            bad++;
            $display("FAIL align_lb_42: got %h want %h", M_dataOut, 32'hFFFF_FFAD);
        end
        putLoad(3'b111, 32'h41);
        total++;
        if (M_dataOut !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL align_op7_word: got %h want %h", M_dataOut, 32'hDEAD_BEEF);
        end
        @(negedge clk);
    endtask

    task automatic test_out_of_range;
        putStore(OP_W, 32'h2FFC, 32'h0BAD_F00D, 32'h0000_3010);
        @(negedge clk);
        putStore(OP_W, 32'h3000, 32'hFFFF_FFFF, 32'h0000_3014);
        @(negedge clk);
        putStore(OP_W, 32'hFFFF_FFFC, 32'h1111_1111, 32'h0000_3018);
        @(negedge clk);
        putLoad(OP_W, 32'h3000);
        total++;
        if (M_dataOut !== 32'h0) begin
            bad++;
            $display("FAIL oor_lw_3000: got %h want %h", M_dataOut, 32'h0);
        end
        putLoad(OP_W, 32'hFFFF_FFFC);
        total++;
        if (M_dataOut !== 32'h0) begin
            bad++;
            $display("FAIL oor_lw_fffffffc: got %h want %h", M_dataOut, 32'h0);
        end
        putLoad(OP_W, 32'h2FFC);
        total++;
        if (M_dataOut !== 32'h0BAD_F00D) begin
            bad++;
            $display("FAIL oor_lw_2ffc: got %h want %h", M_dataOut, 32'h0BAD_F00D);
        end
        putLoad(OP_BU, 32'h2FFF);
        total++;
        if (M_dataOut !== 32'h0000_000B) begin
            bad++;
            $display("FAIL oor_lbu_2fff: got %h want %h", M_dataOut, 32'h0000_000B);
        end
        putLoad(OP_W, 32'h0);
        total++;
        if (M_dataOut !== 32'h0) begin
            bad++;
            $display("FAIL oor_word0_untouched: got %h want %h", M_dataOut, 32'h0);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        putStore(OP_BU, 32'h50, 32'hFFFF_FF11, 32'h0000_301C);
        @(negedge clk);
        putStore(OP_BS, 32'h51, 32'hFFFF_FF22, 32'h0000_3020);
        @(negedge clk);
        putStore(OP_HU, 32'h52, 32'hFFFF_3344, 32'h0000_3024);
        @(negedge clk);
        putLoad(OP_W, 32'h50);
        total++;
        if (M_dataOut !== 32'h3344_2211) begin
            bad++;
            $display("FAIL b2b_lw: got %h want %h", M_dataOut, 32'h3344_2211);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        putStore(OP_W, 32'h8, 32'h0000_0005, 32'h0000_3028);
        @(negedge clk);
        putLoad(OP_W, 32'h8);
        total++;
        if (M_dataOut !== 32'h0000_0005) begin
            bad++;
            $display("FAIL rmid_before_reset: got %h want %h", M_dataOut, 32'h5);
        end
        #1 reset = 1'b1;
        #1;
        total++;
        if (M_dataOut !== 32'h0) begin
            bad++;
            $display("FAIL rmid_async_clear: got %h want %h", M_dataOut, 32'h0);
        end
        putStore(OP_W, 32'hC, 32'h0000_0006, 32'h0000_302C);
        @(negedge clk);
        reset = 1'b0;
        putLoad(OP_W, 32'hC);
        total++;
        if (M_dataOut !== 32'h0) begin
            bad++;
            $display("FAIL rmid_store_dropped: got %h want %h", M_dataOut, 32'h0);
        end
        putLoad(OP_W, 32'h10);
        total++;
        if (M_dataOut !== 32'h0) begin
            bad++;
            $display("FAIL rmid_old_word_cleared: got %h want %h", M_dataOut, 32'h0);
        end
        putStore(OP_W, 32'hC, 32'h0000_0077, 32'h0000_3030);
        @(negedge clk);
        putLoad(OP_W, 32'hC);
        total++;
        if (M_dataOut !== 32'h0000_0077) begin
            bad++;
            $display("FAIL rmid_first_store_after: got %h want %h", M_dataOut, 32'h77);
        end
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        M_PC        = 32'h0;
        M_memWrite  = 1'b0;
        M_memOp     = OP_W;
        M_addr      = 32'h0;
        M_writeData = 32'h0;
        test_reset;
        test_word_store;
        test_merge;
        test_align;
        test_out_of_range;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m_dm.md
# m_dm

Data memory for the M stage of the five-stage pipeline: word-array storage with byte/halfword/word stores and sign- or zero-extended loads. Sits between M_REG and W_REG. Address and store data come from the M-stage pipeline register, and the load result drives W_REG's `M_dataOut` input. Stores commit on the clock edge. Loads are combinational within the M cycle. Every committed store is logged for the course comparison harness.

## Interface
- `DEPTH`, 3072: number of 32-bit words (12 KiB).
- `BASE`, 32'h0000_0000: byte address of word 0.
- `clk` input 1: pipeline clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high; clears the whole array.
- `M_PC` input 32: PC of the M-stage instruction; used only for the store log.
- `M_memWrite` input 1: 1 = the M-stage instruction is a store.
- `M_memOp` input 3: access type.
  - 3'b000 = word.
  - 3'b001 = half, signed.
  - 3'b010 = half, unsigned.
  - 3'b011 = byte, signed.
  - 3'b100 = byte, unsigned.
  - Other codes are treated as word.
- `M_addr` input 32: byte address.
- `M_writeData` input 32: store data; the low 8/16/32 bits are used.
- `M_dataOut` output 32: load result, extended per `M_memOp`.

## Operation
- Offset `off = M_addr - BASE` (32-bit, wrapping).
  - Word index `idx = off[31:2]`.
  - In range iff `off < DEPTH*4` (unsigned).
- Alignment is forced, never trapped.
  - Word accesses ignore `off[1:0]`.
  - Half accesses ignore `off[0]` and select lane `off[1]`: 0 = bits [15:0], 1 = bits [31:16].
  - Byte accesses select lane `off[1:0]`: 0 = bits [7:0] … 3 = bits [31:24].
- Store, when `M_memWrite`=1, in range and `reset`=0:
  - Read-modify-write of `mem[idx]`; only the selected lane(s) change.
  - Lane data is taken from `M_writeData[7:0]` (byte), `[15:0]` (half) or `[31:0]` (word).
  - Signed and unsigned codes store identically.
- Store out of range: ignored; no array change, no log line.
- Store log: on each committed store, at the same edge, print `"%d@%h: *%h <= %h"` with these fields:
  - `$time`
  - `M_PC`
  - word-aligned byte address `BASE + idx*4`
  - the full merged 32-bit word after the store
- Load path: `M_dataOut` is a pure combinational function of `mem[idx]`, `off` and `M_memOp`, independent of `M_memWrite`.
  - Signed types sign-extend from bit 15 (half) or bit 7 (byte).
  - Unsigned types zero-extend.
  - Out of range: `M_dataOut` = 0.
- Reset: all `DEPTH` words become 0 immediately on `reset` rising, without waiting for `clk`.
  - Stores are suppressed and not logged while `reset`=1.

## Timing
- Reset values: every word 0; hence `M_dataOut` = 0 for any address/op while `reset`=1.
- Load latency 0: `M_dataOut` is valid in the same cycle `M_addr`/`M_memOp` are presented. W_REG captures it at the next edge.
- Store latency 1: new contents are visible on `M_dataOut` from the cycle after the committing edge.
  - A load in the store's own cycle sees the old word.
- Back-to-back stores to the same word each merge into the previous result. For example, sb lane 0 then sb lane 1 in consecutive cycles leaves both bytes written.
- Reset asserted mid-sequence:
  - A store whose edge coincides with `reset`=1 is dropped.
  - The first store after `reset` falls commits normally at the next edge.
- No handshake and no stall: the block accepts one access per cycle unconditionally. Hazard stalling is handled upstream.
- Address wrap: `M_addr` < `BASE` wraps `off` to a large value and is out of range (read 0, write ignored).

## Test plan
- Reset then loads:
  - Pulse `reset` asynchronously between edges.
  - lw at 0x0, 0x2FFC and 0x3000 must all return 0 immediately.
  - No log output.
- Word store/load:
  - sw 0x1234_5678 to 0x10 (PC 0x3000) logs `@00003000: *00000010 <= 12345678`.
  - The next-cycle lw 0x10 returns 0x1234_5678.
  - The same-cycle lw returns 0.
- Byte/half merge on word 0x20, starting from 0:
  - sb 0xAB at 0x23, then sh 0x80FF at 0x20.
  - The word is 0xAB00_80FF after the two edges; the second log shows `<= ab0080ff`.
  - lb 0x23 returns 0xFFFF_FFAB; lbu 0x23 returns 0x0000_00AB.
  - lh 0x20 returns 0xFFFF_80FF; lhu 0x22 returns 0x0000_AB00.
- Forced alignment:
  - sw 0xDEAD_BEEF to 0x43 writes word 0x40.
  - lh 0x41 returns lane 0 = 0xFFFF_BEEF.
- Out of range:
  - sw to 0x3000 (DEPTH 3072) produces no log and no change.
  - lw 0x3000 returns 0; lw 0x2FFC is unchanged.
- Reset during traffic:
  - Issue sw 0x5 to 0x8.
  - Assert `reset` for the next edge while sw 0x6 to 0xC is presented.
  - Word 0x8 becomes 0 asynchronously and word 0xC stays 0; only the first store is logged.
